perspective_divide: RTL and testbench

Perspective-divide and viewport-mapping stage that sits directly downstream of the vertex transformation stage. It accepts one clip-space vertex (x, y, z, w; signed Q16.16) with a valid strobe and forms the reciprocal 1/w with a sequential divider. It scales x, y and z by that reciprocal to produce normalized device coordinates, then maps x and y to integer screen pixels for the rasterizer. It handles one vertex at a time; a ready output gates acceptance.

---
 rtl/gfx_pkg.sv | 27 ++
 rtl/recip_div.sv | 58 +++++
 rtl/perspective_divide.sv | 175 +++++++++++++++++
 tb/tb_perspective_divide.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared fixed-point types and helpers for the geometry pipeline stages.
// Q16.16 signed format throughout; sat32 narrows a wide product back to Q16.16.
package gfx_pkg;

    localparam int          FRAC_BITS = 16;
    localparam logic [31:0] FX_ONE    = 32'h0001_0000;

    typedef logic signed [31:0] fx_t;
    typedef fx_t [3:0]          vec4_t;   // [3]=x, [2]=y, [1]=z, [0]=w

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_MUL  = 2'd2,
        S_VIEW = 2'd3
    } pd_state_e;

    function automatic fx_t sat32(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        else if (v < -64'sh0000_0000_8000_0000)
            return 32'sh8000_0000;
        else
            return fx_t'(v[31:0]);
    endfunction

endpackage

// File: rtl/recip_div.sv
// Restoring divider producing floor(2^32 / d) as a Q16.16 reciprocal.
// done_o marks the cycle of the final iteration; recip_o is valid from the next cycle.
module recip_div
    import gfx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] dvs_i,
    output logic        done_o,
    output logic [31:0] recip_o
);

    logic        busy_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [32:0] quo_q;
    logic [31:0] dvs_q;

    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_d;
    logic [32:0] quo_d;

    // The dividend 2^32 has a single set bit, which is the first one shifted in.
    always_comb begin
        rem_sh = {rem_q, (cnt_q == 6'd0)};
        ge     = (rem_sh >= {1'b0, dvs_q});
        rem_d  = ge ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
        quo_d  = {quo_q[31:0], ge};
    end

    assign done_o  = busy_q && (cnt_q == 6'd32);
    assign recip_o = (quo_q[32] | quo_q[31]) ? 32'h7FFF_FFFF : quo_q[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= dvs_i;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd32)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/perspective_divide.sv
// Perspective divide and viewport map: clip-space vertex -> screen pixel, depth, clip flag.
//   state  | meaning
//   IDLE   | ready, waiting for v_in
//   DIV    | reciprocal of w being formed (33 cycles)
//   MUL    | x, y, z scaled by 1/w into NDC
//   VIEW   | NDC mapped to pixels, results registered, v_out pulsed
module perspective_divide
    import gfx_pkg::*;
#(
    parameter int H_RES = 1280,
    parameter int V_RES = 720
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0][31:0]         pos,
    input  logic                     v_in,
    output logic                     ready,
    output logic [$clog2(H_RES)-1:0] screen_x,
    output logic [$clog2(V_RES)-1:0] screen_y,
    output logic [31:0]              depth,
    output logic                     clipped,
    output logic                     v_out
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam logic signed [63:0] H_S   = 64'(H_RES);
    localparam logic signed [63:0] V_S   = 64'(V_RES);
    localparam logic signed [63:0] X_MAX = 64'(H_RES - 1);
    localparam logic signed [63:0] Y_MAX = 64'(V_RES - 1);
    localparam logic signed [63:0] ONE_S = 64'(FX_ONE);

    pd_state_e     state_q;
    fx_t           x_q, y_q, z_q;
    fx_t           ndc_x_q, ndc_y_q, ndc_z_q;
    logic          reject_q;
    logic [XW-1:0] screen_x_q;
    logic [YW-1:0] screen_y_q;
    fx_t           depth_q;
    logic          clipped_q;
    logic          v_out_q;

    fx_t         w_in;
    logic        w_pos;
    logic        div_start;
    logic        div_done;
    logic [31:0] recip;

    assign w_in      = fx_t'(pos[0]);
    assign w_pos     = (w_in > 0);
    assign div_start = (state_q == S_IDLE) && v_in && w_pos;

    recip_div u_recip_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .dvs_i   (pos[0]),
        .done_o  (div_done),
        .recip_o (recip)
    );

    // Reciprocal never exceeds 0x7FFF_FFFF, so zero-extending keeps it positive.
    logic signed [63:0] r_ext, x_ext, y_ext, z_ext;
    fx_t                ndc_x_d, ndc_y_d, ndc_z_d;

    always_comb begin
        r_ext   = {32'd0, recip};
        x_ext   = {{32{x_q[31]}}, x_q};
        y_ext   = {{32{y_q[31]}}, y_q};
        z_ext   = {{32{z_q[31]}}, z_q};
        ndc_x_d = sat32((x_ext * r_ext) >>> FRAC_BITS);
        ndc_y_d = sat32((y_ext * r_ext) >>> FRAC_BITS);
        ndc_z_d = sat32((z_ext * r_ext) >>> FRAC_BITS);
    end

    logic signed [63:0] nx_ext, ny_ext;
    logic signed [63:0] sx_raw, sy_raw;
    logic               x_off, y_off;
    logic [XW-1:0]      screen_x_d;
    logic [YW-1:0]      screen_y_d;

    // y is flipped so that NDC +1.0 lands on row 0.
    always_comb begin
        nx_ext = {{32{ndc_x_q[31]}}, ndc_x_q};
        ny_ext = {{32{ndc_y_q[31]}}, ndc_y_q};
        sx_raw = ((nx_ext + ONE_S) * H_S) >>> (FRAC_BITS + 1);
        sy_raw = ((ONE_S - ny_ext) * V_S) >>> (FRAC_BITS + 1);
        x_off  = (sx_raw < 0) || (sx_raw > X_MAX);
        y_off  = (sy_raw < 0) || (sy_raw > Y_MAX);

        if (sx_raw < 0)
            screen_x_d = '0;
        else if (sx_raw > X_MAX)
            screen_x_d = X_MAX[XW-1:0];
        else
            screen_x_d = sx_raw[XW-1:0];

        if (sy_raw < 0)
            screen_y_d = '0;
        else if (sy_raw > Y_MAX)
            screen_y_d = Y_MAX[YW-1:0];
        else
            screen_y_d = sy_raw[YW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            ndc_x_q    <= '0;
            ndc_y_q    <= '0;
            ndc_z_q    <= '0;
            reject_q   <= 1'b0;
            screen_x_q <= '0;
            screen_y_q <= '0;
            depth_q    <= '0;
            clipped_q  <= 1'b0;
            v_out_q    <= 1'b0;
        end else begin
            v_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (v_in) begin
                        x_q <= fx_t'(pos[3]);
                        y_q <= fx_t'(pos[2]);
                        z_q <= fx_t'(pos[1]);
                        if (w_pos) begin
                            reject_q <= 1'b0;
                            state_q  <= S_DIV;
                        end else begin
                            reject_q <= 1'b1;
                            state_q  <= S_VIEW;
                        end
                    end
                end
                S_DIV: begin
                    if (div_done)
                        state_q <= S_MUL;
                end
                S_MUL: begin
                    ndc_x_q <= ndc_x_d;
                    ndc_y_q <= ndc_y_d;
                    ndc_z_q <= ndc_z_d;
                    state_q <= S_VIEW;
                end
                S_VIEW: begin
                    if (reject_q) begin
                        screen_x_q <= '0;
                        screen_y_q <= '0;
                        depth_q    <= '0;
                        clipped_q  <= 1'b1;
                    end else begin
                        screen_x_q <= screen_x_d;
                        screen_y_q <= screen_y_d;
                        depth_q    <= ndc_z_q;
                        clipped_q  <= x_off || y_off;
                    end
                    v_out_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign screen_x = screen_x_q;
    assign screen_y = screen_y_q;
    assign depth    = depth_q;
    assign clipped  = clipped_q;
    assign v_out    = v_out_q;

endmodule

// File: tb/tb_perspective_divide.sv
// Scoreboard bench for perspective_divide: directed plan cases plus random vertices
// checked against an arithmetic reference model.
module tb_perspective_divide;

    localparam int H   = 1280;
    localparam int V   = 720;
    localparam int LAT = 35;

    typedef struct {
        longint sx;
        longint sy;
        longint depth;
        bit     clip;
        int     lat;
        int     acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0][31:0] pos = '0;
    logic             v_in = 1'b0;
    logic             ready;
    logic [10:0]      screen_x;
    logic [9:0]       screen_y;
    logic [31:0]      depth;
    logic             clipped;
    logic             v_out;

    perspective_divide #(.H_RES(H), .V_RES(V)) dut (
        .clk      (clk),
        .rst      (rst),
        .pos      (pos),
        .v_in     (v_in),
        .ready    (ready),
        .screen_x (screen_x),
        .screen_y (screen_y),
        .depth    (depth),
        .clipped  (clipped),
        .v_out    (v_out)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_vout = 0;
    int   last_vout_cyc = -1;
    int   last_acc = 0;
    bit   prev_vout = 1'b0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, longint act, longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic longint sat(longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic exp_t mk(longint sx, longint sy, longint d, bit c, int lat);
        exp_t e;
        e.sx = sx; e.sy = sy; e.depth = d; e.clip = c; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // 1/w in Q16.16 is 2^32/w; NDC is c/w; the screen maps [-1,1] onto the pixel grid.
    function automatic exp_t model(int x, int y, int z, int w);
        longint r, nx, ny, nz, sxr, syr;
        exp_t e;
        if (w <= 0) return mk(0, 0, 0, 1'b1, 1);
        r = 64'sd4294967296 / longint'(w);
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        nx = sat((longint'(x) * r) >>> 16);
        ny = sat((longint'(y) * r) >>> 16);
        nz = sat((longint'(z) * r) >>> 16);
        sxr = ((nx + 65536) * H) >>> 17;
        syr = ((65536 - ny) * V) >>> 17;
        e.clip  = (sxr < 0) || (sxr > H - 1) || (syr < 0) || (syr > V - 1);
        e.sx    = (sxr < 0) ? 0 : (sxr > H - 1) ? H - 1 : sxr;
        e.sy    = (syr < 0) ? 0 : (syr > V - 1) ? V - 1 : syr;
        e.depth = nz;
        e.lat   = LAT;
        e.acc   = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_vout = 1'b0;
        end else begin
            if (v_out) begin
                n_vout++;
                check("vout_one_cycle", prev_vout, 0);
                check("ready_with_vout", ready, 1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_vout: got v_out, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("screen_x", screen_x, e.sx);
                    check("screen_y", screen_y, e.sy);
                    check("depth", longint'($signed(depth)), e.depth);
                    check("clipped", clipped, e.clip);
                    check("latency", cyc - e.acc, e.lat);
                end
                last_vout_cyc = cyc;
            end
            prev_vout = v_out;
        end
    end

    task automatic send(logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [31:0] w, exp_t e);
        int t = 0;
        @(negedge clk);
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, expected 1", t);
            return;
        end
        pos  = {x, y, z, w};
        v_in = 1'b1;
        @(posedge clk);
        #1;
        e.acc    = cyc;
        last_acc = cyc;
        sb.push_back(e);
        check("ready_low_after_accept", ready, 0);
        v_in = 1'b0;
    endtask

    task automatic sendm(logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [31:0] w);
        send(x, y, z, w, model(int'(x), int'(y), int'(z), int'(w)));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", sb.size(), 0);
        @(negedge clk);
    endtask

    int c0;
    int a1;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_v_out", v_out, 0);
        check("rst_clipped", clipped, 0);
        check("rst_screen_x", screen_x, 0);
        check("rst_screen_y", screen_y, 0);
        check("rst_depth", depth, 0);

        send(32'h0, 32'h0, 32'h0, 32'h0, mk(0, 0, 0, 1'b1, 1));
        wait_idle();
        send(32'h0, 32'h0, 32'h0, 32'h0001_0000, mk(640, 360, 0, 1'b0, LAT));
        wait_idle();
        send(32'h8000, 32'h8000, 32'h4000, 32'h0001_0000, mk(960, 180, 32'h4000, 1'b0, LAT));
        wait_idle();
        send(32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0002_0000,
             mk(1279, 719, 32'h8000, 1'b1, LAT));
        wait_idle();
        sendm(32'h0000_4000, 32'hFFFF_C000, 32'h0000_1000, 32'hFFFF_0000);
        wait_idle();

        // Second v_in while busy must be ignored.
        c0 = n_vout;
        send(32'h0, 32'h0, 32'h0, 32'h0001_0000, mk(640, 360, 0, 1'b0, LAT));
        repeat (9) @(negedge clk);
        pos  = {32'h0001_0000, 32'h0, 32'h0, 32'hFFFF_FFFF};
        v_in = 1'b1;
        @(negedge clk);
        v_in = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("busy_single_vout", n_vout - c0, 1);

        // Reset in the middle of a divide discards the vertex.
        c0 = n_vout;
        send(32'h8000, 32'h8000, 32'h4000, 32'h0001_0000, mk(960, 180, 32'h4000, 1'b0, LAT));
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_v_out", v_out, 0);
        check("midrst_screen_x", screen_x, 0);
        check("midrst_screen_y", screen_y, 0);
        check("midrst_depth", depth, 0);
        check("midrst_clipped", clipped, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("midrst_no_vout", n_vout - c0, 0);

        // Back-to-back: second vertex taken in the v_out cycle of the first.
        send(32'h0, 32'h0, 32'h0, 32'h0001_0000, mk(640, 360, 0, 1'b0, LAT));
        a1 = last_acc;
        sendm(32'hFFFF_8000, 32'h0000_4000, 32'hFFFF_0000, 32'h0001_0000);
        check("b2b_accept_after_vout", last_acc - last_vout_cyc, 1);
        check("b2b_spacing", last_acc - a1, LAT + 1);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            int unsigned sel;
            int unsigned span;
            logic [31:0] w, x, y, z;
            sel = $urandom_range(0, 9);
            if (sel == 0)
                w = 32'(-int'($urandom_range(0, 32'h40000)));
            else if (sel == 1)
                w = $urandom_range(1, 16);
            else
                w = $urandom_range(32'h1000, 32'h80000);
            span = (sel >= 2) ? w : 32'h10000;
            if (sel >= 8) begin
                x = $urandom;
                y = $urandom;
                z = $urandom;
            end else begin
                x = $urandom_range(0, 2 * span) - span;
                y = $urandom_range(0, 2 * span) - span;
                z = $urandom_range(0, 2 * span) - span;
            end
            sendm(x, y, z, w);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
